// File: rtl/spdif_subframe_sequencer.sv
// -----------------------------------------------------------------------------
// spdif_subframe_sequencer
//
// Assembles S/PDIF subframes from a stream of classified biphase intervals.
// An upstream slicer measures each interval and reports it as 1, 2 or 3 UI
// (UI = half a bit cell). This block finds the preamble (B, M or W), decodes
// the 28 data cells that follow, checks even parity, and presents the result
// on registered outputs. It also tracks lock and flags protocol errors and
// loss of signal.
//
// Interval symbols: 1 UI = zero_i, 2 UI = one_i, 3 UI = head_i.
// Cell decoding:    one 2-UI interval = bit 0, two 1-UI intervals = bit 1.
// Preambles:        B = 3,1,1,3   M = 3,3,1,1   W = 3,2,1,2
//
// Parameters
//   LOCK_CNT  consecutive good subframes before lock_o rises (1..15)
//   TIMEOUT   clk_i cycles without ena_i before a loss of signal (2..255)
//
// Ports
//   clk_i     clock, rising edge
//   nrst_i    asynchronous active-low reset
//   ena_i     one-cycle strobe: an interval has ended, class inputs valid
//   zero_i    interval class 1 UI
//   one_i     interval class 2 UI
//   head_i    interval class 3 UI
//   sample_o  subframe slots 4..27 (LSB = slot 4)
//   v_o/u_o/c_o  validity / user / channel-status bits (slots 28..30)
//   ch_o      0 = channel A (B or M preamble), 1 = channel B (W preamble)
//   blk_o     1 = subframe started with a B preamble
//   valid_o   one-cycle strobe: new error-free subframe on the data outputs
//   err_o     one-cycle strobe: protocol, parity or timeout error
//   lock_o    level: LOCK_CNT good subframes in a row with no error
// -----------------------------------------------------------------------------
module spdif_subframe_sequencer #(
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        ena_i,
  input  logic        zero_i,
  input  logic        one_i,
  input  logic        head_i,
  output logic [23:0] sample_o,
  output logic        v_o,
  output logic        u_o,
  output logic        c_o,
  output logic        ch_o,
  output logic        blk_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        lock_o
);

  typedef enum logic [1:0] {
    S_HUNT,  // waiting for a 3-UI interval
    S_PRE,   // collecting the remaining preamble intervals
    S_DATA,  // at a cell boundary
    S_HALF   // one 1-UI interval of a '1' cell seen
  } state_t;

  // Which preamble the second interval committed us to.
  typedef enum logic [1:0] {
    PK_B,
    PK_M,
    PK_W
  } pre_kind_t;

  localparam logic [4:0] SLOT_LAST = 5'd27;
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] WDOG_MAX  = 8'(TIMEOUT);
  localparam logic [3:0] LOCK_MAX  = 4'(LOCK_CNT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state,    state_n;
  pre_kind_t   pre_kind, pre_kind_n;
  logic [1:0]  pre_idx,  pre_idx_n;   // preamble intervals collected so far
  logic [4:0]  slot_cnt, slot_n;      // data slot 0..27 (subframe slot 4..31)
  logic [27:0] shreg,    shreg_n;     // bits enter at the top, slot 4 ends at [0]
  logic        cand_ch,  cand_ch_n;
  logic        cand_blk, cand_blk_n;
  logic [7:0]  wdog,     wdog_n;
  logic [3:0]  good_cnt, good_n;

  // ---------------------------------------------------------------------------
  // Interval classification
  // ---------------------------------------------------------------------------
  logic [2:0] cls;
  logic       is_1ui, is_2ui, is_3ui, class_ok;

  assign cls      = {head_i, one_i, zero_i};
  assign is_1ui   = (cls == 3'b001);
  assign is_2ui   = (cls == 3'b010);
  assign is_3ui   = (cls == 3'b100);
  assign class_ok = is_1ui | is_2ui | is_3ui;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic proto_err, tmo_err, shift_en, shift_bit, frame_done, parity_bad;
  logic pre_match;
  logic valid_n, err_n;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n    = state;
    pre_kind_n = pre_kind;
    pre_idx_n  = pre_idx;
    slot_n     = slot_cnt;
    shreg_n    = shreg;
    cand_ch_n  = cand_ch;
    cand_blk_n = cand_blk;
    proto_err  = 1'b0;
    tmo_err    = 1'b0;
    shift_en   = 1'b0;
    shift_bit  = 1'b0;
    frame_done = 1'b0;
    pre_match  = 1'b0;

    if (ena_i) begin
      unique case (state)
        S_HUNT: begin
          if (!class_ok) begin
            proto_err = 1'b1;
          end else if (is_3ui) begin
            state_n   = S_PRE;
            pre_idx_n = 2'd1;
          end
        end

        S_PRE: begin
          if (!class_ok) begin
            proto_err = 1'b1;
          end else begin
            case (pre_idx)
              2'd1: begin
                // Second interval selects the preamble: 1 -> B, 2 -> W, 3 -> M.
                pre_idx_n = 2'd2;
                if (is_1ui)      pre_kind_n = PK_B;
                else if (is_2ui) pre_kind_n = PK_W;
                else             pre_kind_n = PK_M;
              end
              2'd2: begin
                // Every preamble has a 1-UI third interval.
                if (is_1ui) pre_idx_n = 2'd3;
                else        proto_err = 1'b1;
              end
              default: begin
                unique case (pre_kind)
                  PK_B:    pre_match = is_3ui;
                  PK_M:    pre_match = is_1ui;
                  PK_W:    pre_match = is_2ui;
                  default: pre_match = 1'b0;
                endcase
                if (pre_match) begin
                  state_n    = S_DATA;
                  slot_n     = 5'd0;
                  cand_ch_n  = (pre_kind == PK_W);
                  cand_blk_n = (pre_kind == PK_B);
                end else begin
                  proto_err = 1'b1;
                end
              end
            endcase
          end
        end

        S_DATA: begin
          if (is_2ui) begin
            shift_en  = 1'b1;
            shift_bit = 1'b0;
          end else if (is_1ui) begin
            state_n = S_HALF;
          end else begin
            proto_err = 1'b1;
          end
        end

        S_HALF: begin
          if (is_1ui) begin
            shift_en  = 1'b1;
            shift_bit = 1'b1;
            state_n   = S_DATA;
          end else begin
            proto_err = 1'b1;
          end
        end
      endcase
    end else if (state != S_HUNT && wdog == WDOG_LAST) begin
      tmo_err = 1'b1;
      state_n = S_HUNT;
    end

    if (shift_en) begin
      shreg_n = {shift_bit, shreg[27:1]};
      if (slot_cnt == SLOT_LAST) begin
        frame_done = 1'b1;
        state_n    = S_HUNT;
      end else begin
        slot_n = slot_cnt + 5'd1;
      end
    end

    // A lone 3-UI interval that breaks the current frame is most likely the
    // start of the next preamble, so restart collection instead of hunting.
    if (proto_err) begin
      if (is_3ui) begin
        state_n   = S_PRE;
        pre_idx_n = 2'd1;
      end else begin
        state_n = S_HUNT;
      end
    end
  end

  // Slots 4..31 must XOR to zero; only meaningful when a frame completes.
  assign parity_bad = ^shreg_n;
  assign valid_n    = frame_done & ~parity_bad;
  assign err_n      = proto_err | tmo_err | (frame_done & parity_bad);

  always_comb begin
    good_n = good_cnt;
    if (err_n)                               good_n = 4'd0;
    else if (valid_n && good_cnt != LOCK_MAX) good_n = good_cnt + 4'd1;
  end

  always_comb begin
    wdog_n = wdog;
    if (ena_i)                 wdog_n = 8'd0;
    else if (wdog != WDOG_MAX) wdog_n = wdog + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state    <= S_HUNT;
      pre_kind <= PK_B;
      pre_idx  <= 2'd0;
      slot_cnt <= 5'd0;
      // NOTE: the shift register is cleared as well, so a frame interrupted
      // by reset leaves nothing behind that could leak into the next one.
      shreg    <= 28'd0;
      cand_ch  <= 1'b0;
      cand_blk <= 1'b0;
      wdog     <= 8'd0;
      good_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      pre_kind <= pre_kind_n;
      pre_idx  <= pre_idx_n;
      slot_cnt <= slot_n;
      shreg    <= shreg_n;
      cand_ch  <= cand_ch_n;
      cand_blk <= cand_blk_n;
      wdog     <= wdog_n;
      good_cnt <= good_n;
    end
  end

  // Outputs. lock_o is derived from the next counter value so it falls in
  // the same cycle as err_o and rises with the LOCK_CNT-th valid_o.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sample_o <= 24'd0;
      v_o      <= 1'b0;
      u_o      <= 1'b0;
      c_o      <= 1'b0;
      ch_o     <= 1'b0;
      blk_o    <= 1'b0;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
      lock_o   <= 1'b0;
    end else begin
      valid_o <= valid_n;
      err_o   <= err_n;
      lock_o  <= (good_n == LOCK_MAX);
      if (valid_n) begin
        sample_o <= shreg_n[23:0];
        v_o      <= shreg_n[24];
        u_o      <= shreg_n[25];
        c_o      <= shreg_n[26];
        ch_o     <= cand_ch;
        blk_o    <= cand_blk;
      end
    end
  end

endmodule

// File: tb/tb_spdif_subframe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spdif_subframe_sequencer
//
// Directed bench for spdif_subframe_sequencer. Builds subframes from interval
// symbols (1 UI = zero_i, 2 UI = one_i, 3 UI = head_i) and checks outputs
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spdif_subframe_sequencer;

  localparam logic [2:0] C1 = 3'b001;  // 1 UI
  localparam logic [2:0] C2 = 3'b010;  // 2 UI
  localparam logic [2:0] C3 = 3'b100;  // 3 UI

  localparam int PRE_B = 0;
  localparam int PRE_M = 1;
  localparam int PRE_W = 2;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        ena_i;
  logic        zero_i, one_i, head_i;
  logic [23:0] sample_o;
  logic        v_o, u_o, c_o, ch_o, blk_o, valid_o, err_o, lock_o;

  int checks   = 0;
  int failures = 0;
  int n_err    = 0;
  int n_valid  = 0;
  int n_both   = 0;

  spdif_subframe_sequencer #(
    .LOCK_CNT(4),
    .TIMEOUT (32)
  ) dut (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .ena_i   (ena_i),
    .zero_i  (zero_i),
    .one_i   (one_i),
    .head_i  (head_i),
    .sample_o(sample_o),
    .v_o     (v_o),
    .u_o     (u_o),
    .c_o     (c_o),
    .ch_o    (ch_o),
    .blk_o   (blk_o),
    .valid_o (valid_o),
    .err_o   (err_o),
    .lock_o  (lock_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (err_o === 1'b1)                     n_err++;
    if (valid_o === 1'b1)                   n_valid++;
    if (valid_o === 1'b1 && err_o === 1'b1) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One interval: ena_i high for exactly one rising edge. Returns at the
  // falling edge after that rising edge, where the registered response shows.
  task automatic send(input logic [2:0] cls);
    @(negedge clk_i);
    ena_i = 1'b1;
    {head_i, one_i, zero_i} = cls;
    @(negedge clk_i);
    ena_i = 1'b0;
    {head_i, one_i, zero_i} = 3'b000;
  endtask

  task automatic send_cell(input logic b);
    if (b) begin
      send(C1);
      send(C1);
    end else begin
      send(C2);
    end
  endtask

  task automatic send_pre_tail(input int kind);
    case (kind)
      PRE_B:   begin send(C1); send(C1); send(C3); end
      PRE_M:   begin send(C3); send(C1); send(C1); end
      default: begin send(C2); send(C1); send(C2); end
    endcase
  endtask

  task automatic send_pre(input int kind);
    send(C3);
    send_pre_tail(kind);
  endtask

  task automatic send_data(input logic [27:0] word, input int ncells);
    for (int i = 0; i < ncells; i++) send_cell(word[i]);
  endtask

  // Slots 4..31 packed LSB first; slot 31 makes the XOR even unless bad is set.
  function automatic logic [27:0] make_word(input logic [23:0] s, input logic v,
                                            input logic u, input logic c,
                                            input logic bad);
    logic p;
    p = ^{c, u, v, s} ^ bad;
    return {p, c, u, v, s};
  endfunction

  int e0;

  initial begin
    nrst_i = 1'b1;
    ena_i  = 1'b0;
    zero_i = 1'b0;
    one_i  = 1'b0;
    head_i = 1'b0;

    // ---- Asynchronous reset before any clock edge ----
    #1 nrst_i = 1'b0;
    #1;
    check("reset_sample", 32'(sample_o), 32'd0);
    check("reset_flags", 32'({v_o, u_o, c_o, ch_o, blk_o, valid_o, err_o, lock_o}), 32'd0);
    repeat (3) @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // ---- B subframe, sample A5A5A5, V=0 U=1 C=0 ----
    send_pre(PRE_B);
    send_data(make_word(24'hA5A5A5, 1'b0, 1'b1, 1'b0, 1'b0), 28);
    check("b_valid", 32'(valid_o), 32'd1);
    check("b_sample", 32'(sample_o), 32'hA5A5A5);
    check("b_vuc", 32'({v_o, u_o, c_o}), 32'b010);
    check("b_ch_blk", 32'({ch_o, blk_o}), 32'b01);
    check("b_lock", 32'(lock_o), 32'd0);
    @(negedge clk_i);
    check("b_valid_pulse_end", 32'(valid_o), 32'd0);
    #1;
    check("b_no_err", 32'(n_err), 32'd0);
    check("b_one_valid", 32'(n_valid), 32'd1);

    // ---- W, M, W: lock rises with the 4th good subframe ----
    send_pre(PRE_W);
    send_data(make_word(24'h123456, 1'b1, 1'b0, 1'b1, 1'b0), 28);
    check("w1_valid", 32'(valid_o), 32'd1);
    check("w1_ch_blk", 32'({ch_o, blk_o}), 32'b10);
    check("w1_sample", 32'(sample_o), 32'h123456);
    check("w1_vuc", 32'({v_o, u_o, c_o}), 32'b101);
    send_pre(PRE_M);
    send_data(make_word(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0), 28);
    check("m_valid", 32'(valid_o), 32'd1);
    check("m_ch_blk", 32'({ch_o, blk_o}), 32'b00);
    check("m_lock_low", 32'(lock_o), 32'd0);
    send_pre(PRE_W);
    send_data(make_word(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0), 28);
    check("w2_valid", 32'(valid_o), 32'd1);
    check("w2_ch_blk", 32'({ch_o, blk_o}), 32'b10);
    check("w2_lock", 32'(lock_o), 32'd1);
    check("w2_sample", 32'(sample_o), 32'hFFFFFF);

    // ---- Bad parity while locked ----
    send_pre(PRE_M);
    send_data(make_word(24'h0F0F0F, 1'b1, 1'b1, 1'b1, 1'b1), 28);
    check("par_err", 32'(err_o), 32'd1);
    check("par_no_valid", 32'(valid_o), 32'd0);
    check("par_lock_fall", 32'(lock_o), 32'd0);
    check("par_sample_hold", 32'(sample_o), 32'hFFFFFF);
    check("par_ch_hold", 32'({ch_o, blk_o}), 32'b10);
    @(negedge clk_i);
    check("par_err_pulse_end", 32'(err_o), 32'd0);

    // ---- Broken preamble 3,1,2 ----
    send(C3);
    send(C1);
    check("pre312_no_early_err", 32'(err_o), 32'd0);
    send(C2);
    check("pre312_err", 32'(err_o), 32'd1);
    send(C1);  // ignored in HUNT
    check("hunt_ignores_1ui", 32'(err_o), 32'd0);
    send_pre(PRE_B);
    send_data(make_word(24'h5A5A5A, 1'b0, 1'b0, 1'b1, 1'b0), 28);
    check("after312_valid", 32'(valid_o), 32'd1);
    check("after312_sample", 32'(sample_o), 32'h5A5A5A);

    // ---- head_i at data slot 10 restarts the preamble ----
    send_pre(PRE_B);
    send_data(make_word(24'hFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0), 10);
    send(C3);
    check("slot10_err", 32'(err_o), 32'd1);
    send_pre_tail(PRE_M);
    send_data(make_word(24'hC3C3C3, 1'b0, 1'b1, 1'b1, 1'b0), 28);
    check("slot10_valid", 32'(valid_o), 32'd1);
    check("slot10_ch_blk", 32'({ch_o, blk_o}), 32'b00);
    check("slot10_sample", 32'(sample_o), 32'hC3C3C3);
    check("slot10_vuc", 32'({v_o, u_o, c_o}), 32'b011);

    // ---- Timeout in DATA ----
    send_pre(PRE_B);
    send_data(28'h0000015, 5);
    #1 e0 = n_err;
    repeat (31) @(negedge clk_i);
    #1;
    check("tmo_quiet_31", 32'(n_err), 32'(e0));
    @(negedge clk_i);
    check("tmo_err_at_32", 32'(err_o), 32'd1);
    check("tmo_lock", 32'(lock_o), 32'd0);
    @(negedge clk_i);
    check("tmo_err_pulse_end", 32'(err_o), 32'd0);
    repeat (40) @(negedge clk_i);
    #1;
    check("tmo_single_err", 32'(n_err), 32'(e0 + 1));

    // ---- Two class bits at once ----
    send_pre(PRE_B);
    send_data(28'h0000003, 2);
    send(3'b011);
    check("two_class_err", 32'(err_o), 32'd1);

    // ---- Reset mid-subframe ----
    send_pre(PRE_W);
    send_data(make_word(24'h777777, 1'b0, 1'b0, 1'b0, 1'b0), 20);
    nrst_i = 1'b0;
    #1;
    check("midrst_sample", 32'(sample_o), 32'd0);
    check("midrst_flags", 32'({v_o, u_o, c_o, ch_o, blk_o, valid_o, err_o, lock_o}), 32'd0);
    e0 = n_err + n_valid;
    repeat (2) @(negedge clk_i);
    nrst_i = 1'b1;
    repeat (50) @(negedge clk_i);
    #1;
    check("midrst_no_pulses", 32'(n_err + n_valid), 32'(e0));
    send_pre(PRE_B);
    send_data(make_word(24'h3C3C3C, 1'b1, 1'b0, 1'b0, 1'b0), 28);
    check("midrst_recover", 32'(valid_o), 32'd1);
    check("midrst_recover_sample", 32'(sample_o), 32'h3C3C3C);

    #1;
    check("never_valid_and_err", 32'(n_both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/spdif_subframe_sequencer.md
SPDIF_SUBFRAME_SEQUENCER -- requirements
Module: spdif_subframe_sequencer

Interface
REQ-001 Parameter: LOCK_CNT, 4, number of consecutive error-free subframes required before lock_o asserts (range 1..15).
REQ-002 Parameter: TIMEOUT, 32, clk_i cycles without ena_i before the sequencer declares signal loss (range 2..255).
REQ-003 clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 nrst_i  input  1  asynchronous, active-low reset.
REQ-005 ena_i  input  1  one-cycle strobe: one biphase interval has ended; class inputs are sampled only in this cycle.
REQ-006 zero_i / one_i / head_i  input  1 each  interval class: 1 UI / 2 UI / 3 UI (UI = half a bit cell).
REQ-007 sample_o  output  24  subframe slots 4..27; LSB = slot 4.
REQ-008 v_o, u_o, c_o  output  1 each  validity, user and channel-status bits (slots 28, 29, 30).
REQ-009 ch_o  output  1  0 = channel A (B or M preamble), 1 = channel B (W preamble).
REQ-010 blk_o  output  1  1 = subframe began with a B preamble (block start).
REQ-011 valid_o  output  1  one-cycle strobe: new error-free subframe on the data outputs.
REQ-012 err_o  output  1  one-cycle strobe: protocol, parity or timeout error.
REQ-013 lock_o  output  1  level: receiver locked.

Function
REQ-014 An ena_i cycle where the number of asserted class inputs is not exactly one SHALL be a protocol error.
REQ-015 States: HUNT, PRE (preamble collection), DATA (expecting a cell), HALF (one 1-UI interval seen in the current cell).
REQ-016 HUNT: ena_i with head_i SHALL go to PRE, clear the preamble interval index, and record interval 1 = 3; any other class SHALL stay in HUNT with no error.
REQ-017 PRE: the sequencer SHALL collect three further intervals; complete patterns are B = 3,1,1,3, M = 3,3,1,1 and W = 3,2,1,2.
REQ-018 The sequencer SHALL check each PRE interval as it arrives, and SHALL flag a protocol error at the first interval that cannot lead to B, M or W.
REQ-019 A completed preamble SHALL latch ch_o/blk_o candidates (B: ch 0, blk 1; M: ch 0, blk 0; W: ch 1, blk 0), clear the 5-bit slot counter, and enter DATA.
REQ-020 DATA: a 2-UI interval SHALL shift in bit 0 and advance the slot counter; a 1-UI interval SHALL go to HALF; a 3-UI interval SHALL be a protocol error.
REQ-021 HALF: a 1-UI interval SHALL shift in bit 1, advance the slot counter and return to DATA; any other class SHALL be a protocol error.
REQ-022 Data slots SHALL be counted 0..27 after the preamble, corresponding to subframe slots 4..31.
REQ-023 Parity SHALL be even: the XOR of subframe slots 4..31 equals 0.
REQ-024 On the 28th data bit with good parity, the sequencer SHALL update all data outputs and pulse valid_o in the next cycle (1 cycle after the completing ena_i), then return to HUNT.
REQ-025 On the 28th data bit with bad parity, the data outputs SHALL hold their previous values, err_o SHALL pulse, and the state SHALL return to HUNT.
REQ-026 Data outputs SHALL hold their values between valid_o strobes.
REQ-027 On a protocol error, err_o SHALL pulse next cycle and the sequencer SHALL go to HUNT.
REQ-028 Exception to REQ-027: a head_i that causes a protocol error in DATA, HALF or PRE SHALL go directly to PRE as a new preamble start, with interval 1 = 3.
REQ-029 A watchdog SHALL count cycles without ena_i; reaching TIMEOUT outside HUNT SHALL pulse err_o once and force HUNT.
REQ-030 The watchdog SHALL saturate in HUNT without repeated err_o, and SHALL clear on every ena_i.
REQ-031 A good-subframe counter SHALL increment on each valid_o and saturate at LOCK_CNT; lock_o = (counter == LOCK_CNT).
REQ-032 Any err_o SHALL clear the good-subframe counter, and lock_o SHALL fall in the same cycle as err_o.
REQ-033 valid_o and err_o SHALL never be asserted in the same cycle.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On nrst_i low, without waiting for clk_i, the block SHALL enter HUNT and all outputs, counters, the shift register and the watchdog SHALL be 0.
REQ-036 Reset asserted mid-subframe SHALL discard the partial subframe; no valid_o or err_o pulse SHALL follow it.

Verification
REQ-037 B preamble (3,1,1,3), then 28 cells encoding sample 24'hA5A5A5, V=0 U=1 C=0 with even parity -> one valid_o pulse one cycle after the last ena_i; sample_o=24'hA5A5A5, u_o=1, ch_o=0, blk_o=1, err_o never asserted.
REQ-038 Four good subframes (B, W, M, W) -> lock_o rises together with the 4th valid_o pulse; ch_o sequence is 0,1,0,1.
REQ-039 Subframe with slot 31 inverted (bad parity) while locked -> err_o pulses, lock_o falls, and sample_o keeps its previous value.
REQ-040 Preamble 3,1,2 -> err_o pulses after the third interval and the state is HUNT; a following head_i enters PRE.
REQ-041 Head_i at data slot 10 -> err_o pulses and the sequencer restarts in PRE; a correct M preamble plus data then produces valid_o with ch_o=0, blk_o=0.
REQ-042 No ena_i for TIMEOUT=32 cycles in DATA -> exactly one err_o pulse at cycle 32 and lock_o=0; ena_i with two class bits set -> err_o pulse.
